sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 118 +++++++++++
 tb/tb_sram_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one SRAM-like bus with at
// most one outstanding transaction; ties alternate between the two requesters.
module sram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [3:0]        bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,

    output logic              stallreq_if,
    output logic              stallreq_mem
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    state_t state;
    logic   owner;
    logic   last_grant;
    logic   grant_inst;
    logic   grant_data;
    logic   done;

    // Data wins a tie only when inst was the last one served.
    always_comb begin
        grant_data = ~rst && (state == IDLE) && data_req && (~inst_req || last_grant == OWN_INST);
        grant_inst = ~rst && (state == IDLE) && inst_req && ~grant_data;
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign bus_req      = ~rst && (state == ADDR);

    assign done = ((state == ADDR) && bus_addr_ok && bus_data_ok) ||
                  ((state == DATA) && bus_data_ok);

    assign stallreq_if  = ~rst && ((inst_req && ~grant_inst) ||
                                   (owner == OWN_INST && state != IDLE));
    assign stallreq_mem = ~rst && ((data_req && ~grant_data) ||
                                   (owner == OWN_DATA && state != IDLE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= OWN_INST;
            last_grant   <= OWN_INST;
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            inst_rdata   <= '0;
            data_rdata   <= '0;
            bus_wr       <= 1'b0;
            bus_wstrb    <= 4'b0000;
            bus_addr     <= '0;
            bus_wdata    <= '0;
        end else begin
            inst_data_ok <= done && (owner == OWN_INST);
            data_data_ok <= done && (owner == OWN_DATA);
            // bus_wr still holds the in-flight access type, so stores skip this.
            if (done && !bus_wr) begin
                if (owner == OWN_INST) inst_rdata <= bus_rdata;
                else                   data_rdata <= bus_rdata;
            end
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        owner      <= OWN_DATA;
                        last_grant <= OWN_DATA;
                        bus_wr     <= data_wr;
                        bus_wstrb  <= data_wstrb;
                        bus_addr   <= data_addr;
                        bus_wdata  <= data_wdata;
                        state      <= ADDR;
                    end else if (grant_inst) begin
                        owner      <= OWN_INST;
                        last_grant <= OWN_INST;
                        bus_wr     <= 1'b0;
                        bus_wstrb  <= 4'b0000;
                        bus_addr   <= inst_addr;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus_addr_ok) state <= bus_data_ok ? IDLE : DATA;
                end
                DATA: begin
                    if (bus_data_ok) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        stallreq_if, stallreq_mem;

    int n_tests = 0;
    int n_fail  = 0;

    sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata), .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: one access in flight, described by who owns it,
    // whether the bus has taken its address yet, and the fields it carries.
    bit          m_busy, m_addr_taken, m_owner_data, m_last_data;
    bit          m_wr, m_wdata_known, m_pulse_i, m_pulse_d;
    logic [3:0]  m_strb;
    logic [31:0] m_addr, m_wdata, m_ir, m_dr;
    bit          seen_iaok, seen_daok;

    always @(negedge clk) begin
        bit win_i, win_d, fin;
        seen_iaok = inst_addr_ok;
        seen_daok = data_addr_ok;
        if (rst) begin
            m_busy = 0; m_addr_taken = 0; m_owner_data = 0; m_last_data = 0;
            m_wr = 0; m_strb = 0; m_addr = 0; m_wdata = 0; m_wdata_known = 1;
            m_pulse_i = 0; m_pulse_d = 0; m_ir = 0; m_dr = 0;
        end else begin
            win_i = 0; win_d = 0;
            if (!m_busy) begin
                if (inst_req && data_req) begin
                    if (m_last_data) win_i = 1; else win_d = 1;
                end else begin
                    win_i = inst_req;
                    win_d = data_req;
                end
            end
            chk("m_inst_addr_ok", inst_addr_ok, win_i);
            chk("m_data_addr_ok", data_addr_ok, win_d);
            chk("m_bus_req", bus_req, m_busy && !m_addr_taken);
            chk("m_bus_addr", bus_addr, m_addr);
            chk("m_bus_wr", bus_wr, m_wr);
            chk("m_bus_wstrb", bus_wstrb, m_strb);
            if (m_wdata_known) chk("m_bus_wdata", bus_wdata, m_wdata);
            chk("m_inst_data_ok", inst_data_ok, m_pulse_i);
            chk("m_data_data_ok", data_data_ok, m_pulse_d);
            chk("m_inst_rdata", inst_rdata, m_ir);
            chk("m_data_rdata", data_rdata, m_dr);
            chk("m_stallreq_if", stallreq_if,
                (inst_req && !win_i) || (m_busy && !m_owner_data));
            chk("m_stallreq_mem", stallreq_mem,
                (data_req && !win_d) || (m_busy && m_owner_data));

            m_pulse_i = 0; m_pulse_d = 0; fin = 0;
            if (!m_busy) begin
                if (win_i || win_d) begin
                    m_busy = 1; m_addr_taken = 0;
                    m_owner_data = win_d; m_last_data = win_d;
                    m_addr = win_d ? data_addr : inst_addr;
                    m_wr   = win_d ? data_wr : 1'b0;
                    m_strb = win_d ? data_wstrb : 4'b0000;
                    if (win_d) m_wdata = data_wdata;
                    m_wdata_known = win_d;
                end
            end else if (!m_addr_taken) begin
                if (bus_addr_ok && bus_data_ok) fin = 1;
                else if (bus_addr_ok) m_addr_taken = 1;
            end else if (bus_data_ok) begin
                fin = 1;
            end
            if (fin) begin
                m_busy = 0;
                if (m_owner_data) m_pulse_d = 1; else m_pulse_i = 1;
                if (!m_wr) begin
                    if (m_owner_data) m_dr = bus_rdata; else m_ir = bus_rdata;
                end
            end
        end
    end

    initial begin
        rst = 1; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0;
        data_wstrb = 0; data_addr = 0; data_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
        repeat (2) tick();
        rst = 0;
        @(negedge clk);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_inst_rdata", inst_rdata, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_stall_if", stallreq_if, 0);

        // Tie straight after reset goes to data; inst waits.
        tick(); inst_req = 1; inst_addr = 32'hBFC0_0000;
        data_req = 1; data_wr = 0; data_addr = 32'h8000_0100;
        @(negedge clk);
        chk("tie_data_aok", data_addr_ok, 1);
        chk("tie_inst_aok", inst_addr_ok, 0);
        chk("tie_stall_if", stallreq_if, 1);
        chk("tie_stall_mem", stallreq_mem, 0);
        tick(); data_req = 0; bus_addr_ok = 1;
        @(negedge clk);
        chk("tie_bus_req", bus_req, 1);
        chk("tie_bus_addr", bus_addr, 32'h8000_0100);
        tick(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h1111_2222;
        data_req = 1; data_addr = 32'h8000_0104;
        @(negedge clk);
        chk("tie_wait_iaok", inst_addr_ok, 0);
        chk("tie_wait_daok", data_addr_ok, 0);
        chk("tie_wait_stall_mem", stallreq_mem, 1);
        tick(); bus_data_ok = 0;
        @(negedge clk);
        chk("tie_data_ok", data_data_ok, 1);
        chk("tie_data_rdata", data_rdata, 32'h1111_2222);
        chk("tie2_inst_aok", inst_addr_ok, 1);
        chk("tie2_data_aok", data_addr_ok, 0);
        chk("tie2_stall_if", stallreq_if, 0);
        // Combined addr_ok+data_ok in ADDR.
        tick(); inst_req = 0; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h5555_6666;
        @(negedge clk);
        chk("comb_bus_req", bus_req, 1);
        chk("comb_bus_addr", bus_addr, 32'hBFC0_0000);
        chk("comb_bus_wstrb", bus_wstrb, 0);
        tick(); bus_addr_ok = 0; bus_data_ok = 0;
        @(negedge clk);
        chk("comb_inst_data_ok", inst_data_ok, 1);
        chk("comb_inst_rdata", inst_rdata, 32'h5555_6666);
        chk("comb_next_daok", data_addr_ok, 1);
        tick(); data_req = 0; bus_addr_ok = 1;
        @(negedge clk);
        chk("comb_pulse_end", inst_data_ok, 0);
        chk("ld2_bus_addr", bus_addr, 32'h8000_0104);
        tick(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0A0B_0C0D;
        @(negedge clk);
        tick(); bus_data_ok = 0;
        @(negedge clk);
        chk("ld2_data_ok", data_data_ok, 1);
        chk("ld2_rdata", data_rdata, 32'h0A0B_0C0D);
        // Spurious bus responses while idle.
        tick(); bus_data_ok = 1; bus_addr_ok = 1;
        @(negedge clk);
        tick(); bus_data_ok = 0; bus_addr_ok = 0;
        @(negedge clk);
        chk("spur_inst_ok", inst_data_ok, 0);
        chk("spur_data_ok", data_data_ok, 0);
        chk("spur_bus_req", bus_req, 0);

        // Store under 5 cycles of address backpressure, inst waiting.
        tick(); data_req = 1; data_wr = 1; data_wstrb = 4'b1111;
        data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("st_daok", data_addr_ok, 1);
        tick(); data_req = 0; data_wr = 0; inst_req = 1; inst_addr = 32'hBFC0_0004;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            chk("bp_bus_req", bus_req, 1);
            chk("bp_bus_addr", bus_addr, 32'h8000_0010);
            chk("bp_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
            chk("bp_bus_wr", bus_wr, 1);
            chk("bp_bus_wstrb", bus_wstrb, 4'b1111);
            chk("bp_inst_aok", inst_addr_ok, 0);
        end
        tick(); bus_addr_ok = 1;
        @(negedge clk);
        tick(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        tick(); bus_data_ok = 0;
        @(negedge clk);
        chk("st_data_ok", data_data_ok, 1);
        chk("st_rdata_hold", data_rdata, 32'h0A0B_0C0D);
        chk("st_next_iaok", inst_addr_ok, 1);

        // Reset while the fetch sits in DATA.
        tick(); inst_req = 0; bus_addr_ok = 1;
        @(negedge clk);
        chk("ab_bus_addr", bus_addr, 32'hBFC0_0004);
        tick(); bus_addr_ok = 0;
        @(negedge clk);
        chk("ab_in_data", bus_req, 0);
        tick(); rst = 1;
        @(negedge clk);
        tick(); rst = 0;
        @(negedge clk);
        chk("ab_bus_req", bus_req, 0);
        chk("ab_inst_ok", inst_data_ok, 0);
        chk("ab_data_ok", data_data_ok, 0);
        chk("ab_inst_rdata", inst_rdata, 0);
        chk("ab_data_rdata", data_rdata, 0);
        chk("ab_bus_addr0", bus_addr, 0);
        chk("ab_bus_wdata", bus_wdata, 0);
        chk("ab_bus_wr", bus_wr, 0);
        chk("ab_bus_wstrb", bus_wstrb, 0);
        chk("ab_stall_if", stallreq_if, 0);
        chk("ab_stall_mem", stallreq_mem, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("ab_no_pulse", inst_data_ok, 0);
        end

        // Single fetch timing.
        tick(); inst_req = 1; inst_addr = 32'hBFC0_0000;
        @(negedge clk);
        chk("f_iaok_T", inst_addr_ok, 1);
        tick(); inst_req = 0; bus_addr_ok = 1;
        @(negedge clk);
        chk("f_bus_req_T1", bus_req, 1);
        tick(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h3C01_0000;
        @(negedge clk);
        chk("f_no_ok_T2", inst_data_ok, 0);
        tick(); bus_data_ok = 0;
        @(negedge clk);
        chk("f_data_ok_T3", inst_data_ok, 1);
        chk("f_rdata_T3", inst_rdata, 32'h3C01_0000);

        // Randomized traffic; the model process checks every cycle.
        for (int c = 0; c < 4000; c++) begin
            tick();
            rst = ($urandom_range(0, 299) == 0);
            if (!inst_req || seen_iaok) begin
                inst_req  = $urandom_range(0, 1);
                inst_addr = $urandom;
            end
            if (!data_req || seen_daok) begin
                data_req   = $urandom_range(0, 1);
                data_wr    = $urandom_range(0, 1);
                data_wstrb = 4'($urandom);
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
            bus_addr_ok = ($urandom_range(0, 2) == 0);
            bus_data_ok = ($urandom_range(0, 2) == 0);
            bus_rdata   = $urandom;
        end
        tick(); rst = 0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
